// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C master core.
// Command and FSM state encodings plus bit phase count.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP
  } i2c_state_e;

  localparam int BIT_PHASES = 4;

endpackage

// File: rtl/i2c_master_core_clk_div.sv
// i2c_clk_div: quarter-bit tick generator.
// Counts while enabled, held at zero when disabled.
module i2c_clk_div #(
  parameter int DIV = 250
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] r_cnt;

  // free-running modulo-DIV counter, cleared whenever disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!en_i || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign tick_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: byte-level I2C master (START/WRITE/READ/STOP).
// Define I2C_ARB_LOST_EN to build arbitration-loss detection.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       mack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rdata_o,
  output logic       sack_o,
  output logic       busy_o,
  output logic       arb_lost_o,
  output logic       scl_o,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       sda_i
);

  localparam logic [1:0] LAST_PH = 2'(BIT_PHASES - 1);

  i2c_state_e r_state, w_state_nxt;
  logic [1:0] r_phase;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_rdata;
  logic       r_rd, r_mack, r_sack;
  logic       r_scl, r_sda, r_sdat;
  logic       w_tick, w_busy, w_accept, w_last_ph, w_arb;
  logic       w_scl, w_sda, w_sdat;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_accept  = !w_busy && cmd_valid_i;
  assign w_last_ph = (r_phase == LAST_PH);

  i2c_clk_div #(.DIV(DIV)) u_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_busy),
    .tick_o (w_tick)
  );

`ifdef I2C_ARB_LOST_EN
  logic r_arb;

  assign w_arb = (r_state == ST_DATA) && !r_rd && w_tick &&
                 (r_phase == 2'd2) && r_sdat && r_sda && !sda_i;

  // sticky loss flag, cleared by the next accepted START
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arb <= 1'b0;
    end else if (w_arb) begin
      r_arb <= 1'b1;
    end else if (w_accept && cmd_i == CMD_START) begin
      r_arb <= 1'b0;
    end
  end

  assign arb_lost_o = r_arb;
`else
  assign w_arb      = 1'b0;
  assign arb_lost_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: commands launch from IDLE, phases advance on ticks
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          unique case (i2c_cmd_e'(cmd_i))
            CMD_START: w_state_nxt = ST_START;
            CMD_STOP:  w_state_nxt = ST_STOP;
            default:   w_state_nxt = ST_DATA;
          endcase
        end
      end
      ST_DATA: begin
        if (w_arb) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && w_last_ph && r_bit == 3'd0) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_START, ST_ACK, ST_STOP: begin
        if (w_tick && w_last_ph) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // bus levels for the current state and phase; IDLE holds the lines
  always_comb begin
    w_scl  = r_scl;
    w_sda  = r_sda;
    w_sdat = r_sdat;
    unique case (r_state)
      ST_START: begin
        w_sdat = 1'b1;
        w_scl  = (r_phase != 2'd3);
        w_sda  = (r_phase < 2'd2);
      end
      ST_DATA: begin
        w_sdat = !r_rd;
        w_scl  = (r_phase == 2'd1) || (r_phase == 2'd2);
        w_sda  = r_rd ? 1'b1 : r_shift[7];
      end
      ST_ACK: begin
        w_sdat = r_rd;
        w_scl  = (r_phase == 2'd1) || (r_phase == 2'd2);
        w_sda  = r_rd ? r_mack : 1'b1;
      end
      ST_STOP: begin
        w_sdat = 1'b1;
        w_scl  = (r_phase != 2'd0);
        w_sda  = (r_phase >= 2'd2);
      end
      default: ;
    endcase
  end

  // datapath: phase/bit counters, shifter, sampled results, bus regs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase <= 2'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_rd    <= 1'b0;
      r_mack  <= 1'b1;
      r_rdata <= 8'h00;
      r_sack  <= 1'b1;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_sdat  <= 1'b0;
    end else begin
      r_scl  <= w_scl;
      r_sda  <= w_sda;
      r_sdat <= w_sdat;
      if (w_accept) begin
        r_phase <= 2'd0;
        r_bit   <= 3'd7;
        r_shift <= wdata_i;
        r_rd    <= (cmd_i == CMD_READ);
        r_mack  <= mack_i;
      end else if (w_tick) begin
        r_phase <= r_phase + 2'd1;
        if (r_state == ST_DATA && r_phase == 2'd2 && r_rd) begin
          r_shift <= {r_shift[6:0], sda_i};
        end
        if (r_state == ST_DATA && r_phase == 2'd3) begin
          r_bit <= r_bit - 3'd1;
          if (!r_rd) begin
            r_shift <= {r_shift[6:0], 1'b0};
          end
        end
        if (r_state == ST_ACK && r_phase == 2'd2) begin
          if (r_rd) begin
            r_rdata <= r_shift;
          end else begin
            r_sack <= sda_i;
          end
        end
        if (r_state == ST_STOP && w_last_ph) begin
          r_scl  <= 1'b1;
          r_sda  <= 1'b1;
          r_sdat <= 1'b0;
        end
      end
      if (w_arb) begin
        r_sdat <= 1'b0;
      end
    end
  end

  assign cmd_ready_o = !w_busy;
  assign busy_o      = w_busy;
  assign rsp_valid_o = (r_state == ST_ACK) && w_tick && w_last_ph;
  assign rdata_o     = r_rdata;
  assign sack_o      = r_sack;
  assign scl_o       = r_scl;
  assign sda_o       = r_sda;
  assign sda_t       = r_sdat;

endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: scoreboard bench for the I2C master core.
// Directed START/WRITE/READ/STOP, back-to-back, reset and arbitration cases.
module tb_i2c_master_core;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_i;
  logic [7:0] wdata_i;
  logic       mack_i;
  logic       rsp_valid_o;
  logic [7:0] rdata_o;
  logic       sack_o;
  logic       busy_o;
  logic       arb_lost_o;
  logic       scl_o;
  logic       sda_o;
  logic       sda_t;
  logic       sda_i;

  logic       ack_bit, rd_mode, rd_bit, force0;
  logic [7:0] rd_byte;
  logic       w_bus;

  i2c_master_core #(.DIV(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .wdata_i     (wdata_i),
    .mack_i      (mack_i),
    .rsp_valid_o (rsp_valid_o),
    .rdata_o     (rdata_o),
    .sack_o      (sack_o),
    .busy_o      (busy_o),
    .arb_lost_o  (arb_lost_o),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .sda_t       (sda_t),
    .sda_i       (sda_i)
  );

  always #5 clk = ~clk;

  // open-drain bus: core drives when sda_t, else slave model
  assign w_bus = sda_t ? sda_o : (rd_mode ? rd_bit : ack_bit);
  assign sda_i = w_bus & ~force0;

  typedef struct {
    logic [7:0] rdata;
    logic       sack;
    bit         is_rd;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errs   = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0;
  int n_rsp = 0, viol = 0, n_stop = 0, ncap = 0;
  int rd_idx = -1;
  logic [31:0] cap = '0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_t = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // handshake counter and acceptance timestamp for WRITE/READ
  always @(posedge clk) begin
    cyc++;
    if (cmd_valid_i && cmd_ready_o) begin
      n_acc++;
      if (cmd_i == CMD_WRITE || cmd_i == CMD_READ) acc_cyc = cyc;
    end
  end

  // monitor: scoreboard pops, bus bit capture, STOP detect, read slave
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && rsp_valid_o) begin
        n_rsp++;
        if (q.size() == 0) begin
          chk("rsp_unexpected", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("rsp_latency", cyc - acc_cyc + 1, 144);
          if (e.is_rd) chk("rsp_rdata", rdata_o, e.rdata);
          else         chk("rsp_sack", sack_o, e.sack);
        end
      end
      if (busy_o && cmd_ready_o) viol++;
      if (scl_o && !prev_scl) begin
        cap = {cap[30:0], sda_i};
        ncap++;
      end
      if (prev_scl && scl_o && sda_i && !prev_sda) n_stop++;
      if (prev_t && !sda_t && rd_mode) begin
        rd_idx = 7;
        rd_bit = rd_byte[7];
      end else if (prev_scl && !scl_o && rd_idx >= 0) begin
        if (rd_idx > 0) begin
          rd_idx--;
          rd_bit = rd_byte[rd_idx];
        end else begin
          rd_idx = -1;
          rd_bit = 1'b1;
        end
      end
      prev_scl = scl_o;
      prev_sda = sda_i;
      prev_t   = sda_t;
    end
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d,
                       input logic m);
    int n = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_i = c;
    wdata_i = d;
    mack_i = m;
    while (!cmd_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) chk("accept_timeout", cmd_ready_o, 1);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) chk({nm, "_timeout"}, busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b_stop, b_acc, n;
    logic [1:0] seq [3];
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i = 2'd0;
    wdata_i = 8'h00;
    mack_i = 1'b0;
    ack_bit = 1'b1;
    rd_mode = 1'b0;
    rd_bit = 1'b1;
    rd_byte = 8'h00;
    force0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_sdat", sda_t, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_sack", sack_o, 1);
    chk("rst_arb", arb_lost_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 1);

    // START, WRITE 0xA5 acked by slave, STOP
    issue(CMD_START, 8'h00, 1'b0);
    wait_idle("start1");
    ack_bit = 1'b0;
    base = ncap;
    q.push_back('{8'h00, 1'b0, 1'b0});
    issue(CMD_WRITE, 8'hA5, 1'b0);
    wait_idle("write1");
    chk("wr_nbits", ncap - base, 9);
    chk("wr_bits", cap[8:1], 8'hA5);
    chk("wr_ackbit", cap[0], 0);
    chk("wr_sack", sack_o, 0);
    ack_bit = 1'b1;
    b_stop = n_stop;
    issue(CMD_STOP, 8'h00, 1'b0);
    wait_idle("stop1");
    chk("stop_edge", n_stop - b_stop, 1);
    chk("stop_scl", scl_o, 1);
    chk("stop_sdat", sda_t, 0);
    chk("stop_busy", busy_o, 0);

    // START, READ 0x3C with master NACK, STOP
    issue(CMD_START, 8'h00, 1'b0);
    wait_idle("start2");
    rd_mode = 1'b1;
    rd_byte = 8'h3C;
    base = ncap;
    q.push_back('{8'h3C, 1'b1, 1'b1});
    issue(CMD_READ, 8'h00, 1'b1);
    wait_idle("read1");
    rd_mode = 1'b0;
    chk("rd_nbits", ncap - base, 9);
    chk("rd_bits", cap[8:1], 8'h3C);
    chk("rd_ackbit", cap[0], 1);
    chk("rd_rdata", rdata_o, 8'h3C);
    issue(CMD_STOP, 8'h00, 1'b0);
    wait_idle("stop2");

    // WRITE 0xFF with SDA pulled low by another master
    issue(CMD_START, 8'h00, 1'b0);
    wait_idle("start3");
    force0 = 1'b1;
    base = n_rsp;
`ifdef I2C_ARB_LOST_EN
    issue(CMD_WRITE, 8'hFF, 1'b0);
    wait_idle("arb_write");
    force0 = 1'b0;
    chk("arb_set", arb_lost_o, 1);
    chk("arb_no_rsp", n_rsp - base, 0);
    chk("arb_release", sda_t, 0);
`else
    q.push_back('{8'h00, 1'b0, 1'b0});
    issue(CMD_WRITE, 8'hFF, 1'b0);
    wait_idle("arb_write");
    force0 = 1'b0;
    chk("arb_tied", arb_lost_o, 0);
    chk("arb_rsp", n_rsp - base, 1);
`endif
    issue(CMD_STOP, 8'h00, 1'b0);
    wait_idle("stop3");

    // back-to-back START, WRITE, STOP with valid held high
    seq[0] = CMD_START;
    seq[1] = CMD_WRITE;
    seq[2] = CMD_STOP;
    ack_bit = 1'b0;
    b_acc = n_acc;
    q.push_back('{8'h00, 1'b0, 1'b0});
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_i = seq[0];
    wdata_i = 8'h81;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!cmd_ready_o && n < 2000) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      if (i < 2) cmd_i = seq[i+1];
      else cmd_valid_i = 1'b0;
    end
    wait_idle("b2b");
    ack_bit = 1'b1;
    chk("b2b_accepts", n_acc - b_acc, 3);
    chk("b2b_arb_clear", arb_lost_o, 0);
    chk("ready_vs_busy", viol, 0);

    // asynchronous reset during bit 4 of a WRITE
    issue(CMD_START, 8'h00, 1'b0);
    wait_idle("start4");
    base = ncap;
    issue(CMD_WRITE, 8'h5A, 1'b0);
    n = 0;
    while (ncap - base < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_scl", scl_o, 1);
    chk("arst_sda", sda_o, 1);
    chk("arst_sdat", sda_t, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rsp", rsp_valid_o, 0);
    chk("arst_rdata", rdata_o, 0);
    chk("arst_sack", sack_o, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    issue(CMD_START, 8'h00, 1'b0);
    chk("arst_restart", busy_o, 1);
    wait_idle("start5");
    issue(CMD_STOP, 8'h00, 1'b0);
    wait_idle("stop5");

    chk("rsp_missing", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
